// File: rtl/sensor_conditioner_pkg.sv
// Shared definitions for the loop-detector conditioning slice:
// lane state enumeration, lamp bit positions and parameter defaults.
package sensor_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUAL   = 2'd1,
        DEMAND = 2'd2,
        STUCK  = 2'd3
    } lane_state_t;

    // Bit positions within the 3-bit lamp state from the signal controller
    localparam int unsigned GREEN  = 0;
    localparam int unsigned YELLOW = 1;
    localparam int unsigned RED    = 2;

    localparam int unsigned DEB_DEFAULT       = 4;
    localparam int unsigned STUCK_LIM_DEFAULT = 1000;

endpackage

// File: rtl/sensor_conditioner_lane_qualifier.sv
// One detector lane: 2-flop synchronizer, debounce/latch FSM with a
// stuck-high watchdog, and registered demand/fault outputs.
module lane_qualifier
    import sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEB       = DEB_DEFAULT,
    parameter int unsigned STUCK_LIM = STUCK_LIM_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic g,
    output logic demand,
    output logic fault
);

    localparam int unsigned CW = (DEB > 1) ? $clog2(DEB + 1) : 1;
    localparam int unsigned RW = $clog2(STUCK_LIM + 1);
    localparam logic [CW-1:0] QLAST = CW'(DEB - 1);
    localparam logic [RW-1:0] RLIM  = RW'(STUCK_LIM);

    logic          sync1;
    logic          s;
    logic [RW-1:0] run_cnt;
    logic [RW-1:0] run_cnt_d;
    logic [CW-1:0] qcnt;
    logic [CW-1:0] qcnt_d;
    lane_state_t   state;
    lane_state_t   state_d;
    logic          demand_d;
    logic          fault_d;

    // Two-flop synchronizer for the asynchronous loop detector input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    // Saturating count of consecutive high samples, cleared by any low sample
    always_comb begin
        run_cnt_d = '0;
        if (s) begin
            run_cnt_d = (run_cnt == RLIM) ? run_cnt : run_cnt + 1'b1;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            qcnt    <= '0;
            run_cnt <= '0;
            demand  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_d;
            qcnt    <= qcnt_d;
            run_cnt <= run_cnt_d;
            demand  <= demand_d;
            fault   <= fault_d;
        end
    end

    // Next-state logic; the stuck check uses the updated run count so the
    // lane enters STUCK on the edge where the run reaches STUCK_LIM
    always_comb begin
        state_d = state;
        qcnt_d  = qcnt;
        unique case (state)
            IDLE: begin
                qcnt_d = '0;
                if (s) begin
                    if (DEB == 1) begin
                        state_d = DEMAND;
                    end else begin
                        state_d = QUAL;
                        qcnt_d  = CW'(1);
                    end
                end
            end
            QUAL: begin
                if (!s) begin
                    state_d = IDLE;
                    qcnt_d  = '0;
                end else if (run_cnt_d == RLIM) begin
                    state_d = STUCK;
                    qcnt_d  = '0;
                end else if (qcnt == QLAST) begin
                    state_d = DEMAND;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d = qcnt + 1'b1;
                end
            end
            DEMAND: begin
                qcnt_d = '0;
                if (s && run_cnt_d == RLIM) begin
                    state_d = STUCK;
                end else if (g && !s) begin
                    state_d = IDLE;
                end
            end
            STUCK: begin
                // qcnt now counts consecutive low samples toward release
                if (s) begin
                    qcnt_d = '0;
                end else if (qcnt == QLAST) begin
                    state_d = IDLE;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d = qcnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                qcnt_d  = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they register alongside it
    always_comb begin
        demand_d = (state_d == DEMAND) || (state_d == STUCK);
        fault_d  = (state_d == STUCK);
    end

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions two asynchronous vehicle loop detectors into qualified,
// latched demand requests for the signal controller.
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEB       = DEB_DEFAULT,
    parameter int unsigned STUCK_LIM = STUCK_LIM_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_a,
    input  logic       raw_b,
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic       sa,
    output logic       sb,
    output logic       fault_a,
    output logic       fault_b
);

    // Yellow and red lamp bits carry no meaning for demand qualification
    logic unused_lamp;
    assign unused_lamp = ^{A[YELLOW], A[RED], B[YELLOW], B[RED]};

    lane_qualifier #(
        .DEB       (DEB),
        .STUCK_LIM (STUCK_LIM)
    ) u_lane_a (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw_a),
        .g      (A[GREEN]),
        .demand (sa),
        .fault  (fault_a)
    );

    lane_qualifier #(
        .DEB       (DEB),
        .STUCK_LIM (STUCK_LIM)
    ) u_lane_b (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw_b),
        .g      (B[GREEN]),
        .demand (sb),
        .fault  (fault_b)
    );

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: stimulus pushes the expected
// outputs for each edge, a monitor pops and compares after every edge.
module tb_sensor_conditioner;

    localparam int DEB = 4;
    localparam int LIM = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       raw_a, raw_b;
    logic [2:0] A, B;
    logic       sa, sb, fault_a, fault_b;

    sensor_conditioner #(
        .DEB       (DEB),
        .STUCK_LIM (LIM)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .raw_a   (raw_a),
        .raw_b   (raw_b),
        .A       (A),
        .B       (B),
        .sa      (sa),
        .sb      (sb),
        .fault_a (fault_a),
        .fault_b (fault_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit sa;
        bit sb;
        bit fa;
        bit fb;
        int cyc;
    } exp_t;

    // Lane reference: delayed raw history plus high/low run lengths and
    // two flags (latched request, stuck watchdog)
    typedef struct {
        bit p1;
        bit p2;
        int hi;
        int lo;
        bit dem;
        bit stk;
    } lane_m_t;

    exp_t    q[$];
    lane_m_t ma, mb;
    int      n_cmp = 0;
    int      n_bad = 0;
    int      cyc   = 0;

    function automatic lane_m_t lane_clear();
        lane_m_t m;
        m.p1 = 0; m.p2 = 0; m.hi = 0; m.lo = 0; m.dem = 0; m.stk = 0;
        return m;
    endfunction

    // Raw seen at edge k acts on the lane at edge k+2 (synchronizer delay)
    function automatic lane_m_t lane_step(lane_m_t m_in, bit raw, bit g);
        lane_m_t m;
        bit      s;
        m    = m_in;
        s    = m.p2;
        m.p2 = m.p1;
        m.p1 = raw;
        m.hi = s ? ((m.hi < LIM) ? m.hi + 1 : m.hi) : 0;
        if (m.stk) begin
            m.lo = s ? 0 : m.lo + 1;
            if (m.lo >= DEB) begin
                m.stk = 0;
                m.dem = 0;
                m.lo  = 0;
            end
        end else if (m.dem) begin
            if (s && m.hi >= LIM) begin
                m.stk = 1;
                m.lo  = 0;
            end else if (g && !s) begin
                m.dem = 0;
            end
        end else if (s && m.hi >= DEB) begin
            m.dem = 1;
        end
        return m;
    endfunction

    task automatic check(string name, int c, bit act, bit exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0b expected %0b", name, c, act, exp);
        end
    endtask

    // Called at a negedge: drive inputs, predict outputs after the next edge
    task automatic drive(bit ra, bit rb, logic [2:0] a, logic [2:0] b);
        exp_t e;
        raw_a = ra;
        raw_b = rb;
        A     = a;
        B     = b;
        ma    = lane_step(ma, ra, a[0]);
        mb    = lane_step(mb, rb, b[0]);
        e.sa  = ma.dem | ma.stk;
        e.sb  = mb.dem | mb.stk;
        e.fa  = ma.stk;
        e.fb  = mb.stk;
        e.cyc = cyc;
        q.push_back(e);
        cyc++;
        @(negedge clk);
    endtask

    task automatic hold(int n, bit ra, bit rb, logic [2:0] a, logic [2:0] b);
        for (int i = 0; i < n; i++) drive(ra, rb, a, b);
    endtask

    // Called at a negedge: asynchronous reset held across one edge
    task automatic do_reset();
        exp_t e;
        reset = 1'b1;
        #1;
        check("rst_async_sa", cyc, sa, 1'b0);
        check("rst_async_sb", cyc, sb, 1'b0);
        check("rst_async_fa", cyc, fault_a, 1'b0);
        check("rst_async_fb", cyc, fault_b, 1'b0);
        ma    = lane_clear();
        mb    = lane_clear();
        e.sa  = 0; e.sb = 0; e.fa = 0; e.fb = 0;
        e.cyc = cyc;
        q.push_back(e);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compare every output after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sa", e.cyc, sa, e.sa);
                check("sb", e.cyc, sb, e.sb);
                check("fault_a", e.cyc, fault_a, e.fa);
                check("fault_b", e.cyc, fault_b, e.fb);
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic
    initial begin
        int  len_a, len_b, drained;
        bit  ra, rb;
        reset = 1'b1;
        raw_a = 1'b0;
        raw_b = 1'b0;
        A     = 3'b100;
        B     = 3'b100;
        ma    = lane_clear();
        mb    = lane_clear();
        repeat (2) @(negedge clk);
        check("reset_sa", cyc, sa, 1'b0);
        check("reset_sb", cyc, sb, 1'b0);
        check("reset_fa", cyc, fault_a, 1'b0);
        check("reset_fb", cyc, fault_b, 1'b0);
        reset = 1'b0;

        // Lane A qualifies under red and stays latched after raw falls
        hold(10, 1, 0, 3'b100, 3'b100);
        hold(6, 0, 0, 3'b100, 3'b100);
        // Short pulse on lane B never qualifies
        hold(3, 0, 1, 3'b100, 3'b100);
        hold(6, 0, 0, 3'b100, 3'b100);
        // Green with detector clear serves lane A in one cycle
        hold(1, 0, 0, 3'b001, 3'b100);
        hold(3, 0, 0, 3'b100, 3'b100);
        // Green while vehicle still present keeps demand
        hold(8, 1, 0, 3'b100, 3'b100);
        hold(3, 1, 0, 3'b001, 3'b001);
        hold(2, 0, 0, 3'b010, 3'b100);
        hold(4, 0, 0, 3'b001, 3'b100);
        // Stuck detector on lane A, then release
        hold(25, 1, 0, 3'b001, 3'b100);
        hold(6, 0, 0, 3'b100, 3'b100);
        hold(3, 0, 0, 3'b001, 3'b100);
        // Simultaneous qualification, then reset mid-DEMAND
        hold(8, 1, 1, 3'b100, 3'b100);
        do_reset();
        hold(4, 0, 0, 3'b100, 3'b100);
        // Reset mid-qualification discards history
        hold(3, 1, 1, 3'b100, 3'b100);
        do_reset();
        hold(8, 1, 1, 3'b100, 3'b100);
        hold(4, 0, 0, 3'b001, 3'b001);

        // Randomized bursts of random length with random lamp states
        len_a = 0;
        len_b = 0;
        ra    = 0;
        rb    = 0;
        for (int i = 0; i < 1500; i++) begin
            if (len_a == 0) begin
                ra    = ~ra;
                len_a = $urandom_range(1, 30);
            end
            if (len_b == 0) begin
                rb    = ~rb;
                len_b = $urandom_range(1, 30);
            end
            len_a--;
            len_b--;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                drive(ra, rb, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end
        end

        @(posedge clk);
        #2;
        drained = q.size();
        n_cmp++;
        if (drained != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", drained);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
